// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for the stopwatch display.
// Scans one digit per SCAN_DIV clocks, decodes BCD to active-low segments,
// lights the colon decimal point on digit 2, and blinks the field being
// adjusted when adjust mode is active.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic       adj,
  input  logic       sel,
  input  logic       blink_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic          blink_phase;

  logic [3:0] cur_digit;
  logic       in_field;
  logic       blank;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  // BCD to active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = 7'b0111111;
    endcase
  endfunction

  // Scan timer: advance the digit slot each time the divider wraps.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Blink phase only runs in adjust mode; leaving adjust mode shows the field.
  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end

  // Select the digit for the current slot and decide whether it is blanked.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    cur_digit = digit_0;
    case (idx)
      2'd0:    cur_digit = digit_0;
      2'd1:    cur_digit = digit_1;
      2'd2:    cur_digit = digit_2;
      default: cur_digit = digit_3;
    endcase

    in_field = sel ? (idx <= 2'd1) : (idx >= 2'd2);
    blank    = adj && blink_phase && in_field;

    if (blank) begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
    end else begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = seg_encode(cur_digit);
      dp_nxt  = (idx == 2'd2) ? 1'b0 : 1'b1;
    end
  end

  // Register the pin drive so outputs are glitch-free with one cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a time-based reference model
// (slot derived from elapsed cycles since reset) checked every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_0 = 4'd0, digit_1 = 4'd0, digit_2 = 4'd0, digit_3 = 4'd0;
  logic       adj = 1'b0, sel = 1'b0, blink_tick = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_0    (digit_0),
    .digit_1    (digit_1),
    .digit_2    (digit_2),
    .digit_3    (digit_3),
    .adj        (adj),
    .sel        (sel),
    .blink_tick (blink_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d <= 9) ? tbl[d] : 7'b0111111;
  endfunction

  // Reference model: the slot shown on the n-th clock after reset is
  // ((n-1) / SCAN_DIV) mod 4; t counts clocks since reset.
  int         t = 0;
  bit         phase = 1'b0;
  bit         model_valid = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;

  always @(posedge clk) begin
    int  slot;
    int  digs [4];
    bit  blanked;
    if (rst) begin
      t           <= 0;
      phase       <= 1'b0;
      exp_an      <= 4'hF;
      exp_seg     <= 7'h7F;
      exp_dp      <= 1'b1;
      model_valid <= 1'b1;
    end else begin
      slot    = (t / SCAN_DIV) % 4;
      digs    = '{int'(digit_0), int'(digit_1), int'(digit_2), int'(digit_3)};
      blanked = adj && phase && (sel ? (slot < 2) : (slot >= 2));
      if (blanked) begin
        exp_an  <= 4'hF;
        exp_seg <= 7'h7F;
        exp_dp  <= 1'b1;
      end else begin
        exp_an  <= 4'hF & ~(4'(1 << slot));
        exp_seg <= ref_seg(digs[slot]);
        exp_dp  <= (slot == 2) ? 1'b0 : 1'b1;
      end
      t     <= t + 1;
      phase <= adj ? (phase ^ blink_tick) : 1'b0;
    end
  end

  // Continuous compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    blink_tick = 1'b1;
    @(negedge clk);
    blink_tick = 1'b0;
  endtask

  // Advance until the next clock will see scan position pos (mod 16).
  task automatic wait_pos(input int pos, input string name);
    int guard = 0;
    while ((t % (4 * SCAN_DIV)) != pos && guard < 64) begin
      step(1);
      guard++;
    end
    if (guard >= 64) check({name, "_timeout"}, 32'(guard), 32'd0);
  endtask

  initial begin
    int blanks;
    int dp_lows;

    // Reset state.
    step(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);

    // Basic scan of 3,2,1,0 across digit_3..digit_0.
    digit_3 = 4'd3; digit_2 = 4'd2; digit_1 = 4'd1; digit_0 = 4'd0;
    rst = 1'b0;
    step(1);
    check("first_an", 32'(an), 32'(4'b1110));
    check("first_seg", 32'(seg), 32'(7'b1000000));
    step(4);
    check("slot1_an", 32'(an), 32'(4'b1101));
    check("slot1_seg", 32'(seg), 32'(7'b1111001));
    step(4);
    check("slot2_an", 32'(an), 32'(4'b1011));
    check("slot2_seg", 32'(seg), 32'(7'b0100100));
    check("slot2_dp", 32'(dp), 32'd0);
    step(4);
    check("slot3_an", 32'(an), 32'(4'b0111));
    check("slot3_seg", 32'(seg), 32'(7'b0110000));
    check("slot3_dp", 32'(dp), 32'd1);
    step(4);
    check("wrap_an", 32'(an), 32'(4'b1110));

    // Out-of-range digit shows a dash.
    digit_1 = 4'hC;
    wait_pos(5, "dash");
    step(1);
    check("dash_an", 32'(an), 32'(4'b1101));
    check("dash_seg", 32'(seg), 32'(7'b0111111));
    digit_1 = 4'd1;

    // Blink seconds field: one pulse blanks slots 0,1, second pulse restores.
    adj = 1'b1; sel = 1'b1;
    step(2);
    pulse_tick();
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (an == 4'hF) blanks++;
    end
    check("blink_sec_blanks", 32'(blanks), 32'd8);
    pulse_tick();
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (an == 4'hF) blanks++;
    end
    check("blink_sec_restored", 32'(blanks), 32'd0);

    // Blink minutes field, then leave adjust mode: everything comes back.
    sel = 1'b0;
    pulse_tick();
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (an == 4'hF) blanks++;
    end
    check("blink_min_blanks", 32'(blanks), 32'd8);
    adj = 1'b0;
    blanks = 0; dp_lows = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (an == 4'hF) blanks++;
      if (dp == 1'b0) dp_lows++;
    end
    check("adj_off_blanks", 32'(blanks), 32'd0);
    check("adj_off_dp_lows", 32'(dp_lows), 32'd4);

    // Reset mid-slot 2 restarts the scan at digit 0 for a full slot.
    wait_pos(10, "midrst");
    rst = 1'b1;
    step(1);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("restart_slot0_an", 32'(an), 32'(4'b1110));
    end
    step(1);
    check("restart_slot1_an", 32'(an), 32'(4'b1101));

    // Digit change mid-slot 0 is visible on the next clock.
    digit_0 = 4'd5;
    wait_pos(1, "midchg");
    step(1);
    check("midchg_seg5", 32'(seg), 32'(7'b0010010));
    digit_0 = 4'd9;
    step(1);
    check("midchg_seg9", 32'(seg), 32'(7'b0010000));
    check("midchg_an", 32'(an), 32'(4'b1110));

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: digit_0 = 4'($urandom_range(0, 15));
          1: digit_1 = 4'($urandom_range(0, 15));
          2: digit_2 = 4'($urandom_range(0, 15));
          default: digit_3 = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 149) == 0) adj = ~adj;
      if ($urandom_range(0, 99) == 0) sel = ~sel;
      blink_tick = (!blink_tick && $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0; blink_tick = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
